// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer: latches a scalar and issues LOAD/DBL/ADD commands to the point unit.
// Optional macro CONST_TIME_EN: fixed schedule (LOAD_INF, then DBL+ADD on every bit with dummy ADDs).
module scalar_mult_ctrl #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_k,
    input  logic             i_op_ready,
    input  logic             i_op_done,
    output logic             o_op_valid,
    output logic [1:0]       o_op_code,
    output logic             o_op_dummy,
    output logic [IDX_W-1:0] o_bit_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_inf
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD_P   = 2'd0,
        OP_DBL      = 2'd1,
        OP_ADD      = 2'd2,
        OP_LOAD_INF = 2'd3
    } op_t;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [KEY_W-1:0] KEY_ZERO = {KEY_W{1'b0}};

    // Index of the most significant set bit (0 when k is zero; caller handles that case).
    function automatic logic [IDX_W-1:0] msb_index(input logic [KEY_W-1:0] k);
        logic [IDX_W-1:0] m;
        m = IDX_ZERO;
        for (int i = 0; i < KEY_W; i++) begin
            if (k[i]) begin
                m = IDX_W'(i);
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // Shift-based bit select keeps the index width independent of KEY_W.
    function automatic logic key_bit(input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] idx);
        logic [KEY_W-1:0] sh;
        sh = k >> idx;
        return sh[0];
    endfunction

    state_t           state_q, state_d;
    op_t              code_q, code_d;
    logic [KEY_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             inf_q, inf_d;
    logic             kbit_s;
`ifdef CONST_TIME_EN
    logic             dummy_q, dummy_d;
`endif

    assign kbit_s = key_bit(k_q, idx_q);

    // Next-state and registered-output computation for the command sequencer.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        k_d     = k_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inf_d   = inf_q;
`ifdef CONST_TIME_EN
        dummy_d = dummy_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_d     = i_k;
                    busy_d  = 1'b1;
                    inf_d   = 1'b0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
`ifdef CONST_TIME_EN
                // Encoder bypassed: the schedule always starts from infinity at the top bit.
                state_d = S_ISSUE;
                valid_d = 1'b1;
                code_d  = OP_LOAD_INF;
                idx_d   = IDX_W'(KEY_W - 1);
                dummy_d = 1'b0;
`else
                if (k_q == KEY_ZERO) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    inf_d   = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_LOAD_P;
                    idx_d   = msb_index(k_q);
                end
`endif
            end
            S_ISSUE: begin
                if (i_op_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (i_op_done) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
`ifdef CONST_TIME_EN
                if (code_q == OP_LOAD_INF) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_DBL;
                    dummy_d = 1'b0;
                end else if (code_q == OP_DBL) begin
                    // ADD always issued; a zero key bit marks it for discard.
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_ADD;
                    dummy_d = ~kbit_s;
                end else if (idx_q == IDX_ZERO) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    inf_d   = (k_q == KEY_ZERO);
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_DBL;
                    idx_d   = idx_q - IDX_ONE;
                    dummy_d = 1'b0;
                end
`else
                if ((code_q == OP_DBL) && kbit_s) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_ADD;
                end else if (idx_q == IDX_ZERO) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    inf_d   = (k_q == KEY_ZERO);
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = OP_DBL;
                    idx_d   = idx_q - IDX_ONE;
                end
`endif
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            code_q  <= OP_LOAD_P;
            k_q     <= KEY_ZERO;
            idx_q   <= IDX_ZERO;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inf_q   <= inf_d;
        end
    end

`ifdef CONST_TIME_EN
    // Dummy-ADD marker register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dummy_q <= 1'b0;
        end else begin
            dummy_q <= dummy_d;
        end
    end

    assign o_op_dummy = dummy_q;
`else
    assign o_op_dummy = 1'b0;
`endif

    assign o_op_valid = valid_q;
    assign o_op_code  = code_q;
    assign o_bit_idx  = idx_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_inf      = inf_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: directed and random scalars checked against a double-and-add schedule model.
module tb_scalar_mult_ctrl;
    localparam int KEY_W = 32;
    localparam int IDX_W = 7;
`ifdef CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [KEY_W-1:0] i_k;
    logic             i_op_ready;
    logic             i_op_done;
    logic             o_op_valid;
    logic [1:0]       o_op_code;
    logic             o_op_dummy;
    logic [IDX_W-1:0] o_bit_idx;
    logic             o_busy;
    logic             o_done;
    logic             o_inf;

    int tests = 0;
    int fails = 0;

    scalar_mult_ctrl #(.KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_k        (i_k),
        .i_op_ready (i_op_ready),
        .i_op_done  (i_op_done),
        .o_op_valid (o_op_valid),
        .o_op_code  (o_op_code),
        .o_op_dummy (o_op_dummy),
        .o_bit_idx  (o_bit_idx),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_inf      (o_inf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, o_op_valid, 0);
        chk({tag, "_code"}, o_op_code, 0);
        chk({tag, "_dummy"}, o_op_dummy, 0);
        chk({tag, "_idx"}, o_bit_idx, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_inf"}, o_inf, 0);
    endtask

    // One full multiplication: hold = cycles ready stays low per command, dly = cycles from accept to done,
    // noise = stray done/start pulses, abort_at = command number during whose WAIT reset is applied (-1: none).
    task automatic run_case(input logic [KEY_W-1:0] k, input int hold, input int dly,
                            input bit noise, input int abort_at);
        logic [1:0] qc[$];
        int         qi[$];
        bit         qd[$];
        int         m, n, exp_cnt;
        bit         exp_inf;

        m = -1;
        for (int i = 0; i < KEY_W; i++) if (k[i]) m = i;
        if (CT) begin
            qc.push_back(2'd3); qi.push_back(KEY_W - 1); qd.push_back(1'b0);
            for (int i = KEY_W - 1; i >= 0; i--) begin
                qc.push_back(2'd1); qi.push_back(i); qd.push_back(1'b0);
                qc.push_back(2'd2); qi.push_back(i); qd.push_back(!k[i]);
            end
            exp_cnt = 1 + 2 * KEY_W;
        end else begin
            if (m >= 0) begin
                qc.push_back(2'd0); qi.push_back(m); qd.push_back(1'b0);
                for (int i = m - 1; i >= 0; i--) begin
                    qc.push_back(2'd1); qi.push_back(i); qd.push_back(1'b0);
                    if (k[i]) begin
                        qc.push_back(2'd2); qi.push_back(i); qd.push_back(1'b0);
                    end
                end
            end
            exp_cnt = (m >= 0) ? (1 + m + ($countones(k) - 1)) : 0;
        end
        exp_inf = (k == '0);

        i_k = k;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_k = $urandom;
        chk("busy_rise", o_busy, 1);
        chk("scan_valid", o_op_valid, 0);
        @(negedge i_clk);
        if (qc.size() == 0) begin
            chk("k0_done", o_done, 1);
            chk("k0_inf", o_inf, 1);
            chk("k0_valid", o_op_valid, 0);
            @(negedge i_clk);
            chk("k0_busy_fall", o_busy, 0);
            chk("k0_done_pulse", o_done, 0);
            return;
        end

        n = 0;
        while (qc.size() > 0) begin
            chk("valid", o_op_valid, 1);
            chk("code", o_op_code, qc[0]);
            chk("idx", o_bit_idx, qi[0]);
            chk("dummy", o_op_dummy, qd[0]);
            n++;
            if (hold > 0) begin
                i_op_ready = 1'b0;
                i_op_done = noise;
                for (int h = 0; h < hold; h++) begin
                    @(negedge i_clk);
                    i_op_done = 1'b0;
                    chk("hold_valid", o_op_valid, 1);
                    chk("hold_code", o_op_code, qc[0]);
                    chk("hold_idx", o_bit_idx, qi[0]);
                end
                i_op_ready = 1'b1;
            end
            @(negedge i_clk);
            chk("accepted", o_op_valid, 0);
            if (abort_at == n - 1) begin
                i_rst = 1'b1;
                #1;
                chk_reset_vals("mid_reset");
                @(negedge i_clk);
                i_rst = 1'b0;
                @(negedge i_clk);
                return;
            end
            if (noise) begin
                i_start = 1'b1;
                i_k = $urandom;
            end
            for (int d = 1; d < dly; d++) begin
                @(negedge i_clk);
                i_start = 1'b0;
                chk("wait_valid", o_op_valid, 0);
            end
            i_op_done = 1'b1;
            @(negedge i_clk);
            i_op_done = 1'b0;
            i_start = 1'b0;
            chk("next_valid", o_op_valid, 0);
            chk("next_done", o_done, 0);
            void'(qc.pop_front());
            void'(qi.pop_front());
            void'(qd.pop_front());
            @(negedge i_clk);
        end
        chk("cmd_count", n, exp_cnt);
        chk("done", o_done, 1);
        chk("inf", o_inf, exp_inf);
        chk("busy_at_done", o_busy, 1);
        chk("valid_at_done", o_op_valid, 0);
        @(negedge i_clk);
        chk("done_pulse", o_done, 0);
        chk("busy_fall", o_busy, 0);
        chk("inf_hold", o_inf, exp_inf);
    endtask

    initial begin
        logic [KEY_W-1:0] rk;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_k = '0;
        i_op_ready = 1'b1;
        i_op_done = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_reset_vals("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        run_case(32'd11, 0, 3, 1'b0, -1);
        run_case(32'd0, 0, 2, 1'b0, -1);
        run_case(32'd1, 5, 2, 1'b0, -1);
        run_case(32'h8000_0000, 1, 2, 1'b1, -1);
        run_case(32'd11, 0, 2, 1'b0, 2);
        run_case(32'd5, 0, 2, 1'b0, -1);
        run_case(32'd2, 0, 1, 1'b0, -1);
        run_case(32'hFFFF_FFFF, 0, 1, 1'b0, -1);
        for (int r = 0; r < 8; r++) begin
            rk = $urandom;
            rk = rk >> $urandom_range(0, 31);
            run_case(rk, $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
